parking_occupancy: RTL
======================

# parking_occupancy

Tracks parking-lot occupancy from entry and exit sensors, runs the barrier-gate sequence for each accepted car, and produces the single-cycle `full_trigger` pulse that drives the full-lot flashing indicator downstream. Sits between the raw gate sensors and the indicator/display stages, fully in the `clk_40MHz` domain. Also exports the occupancy count and free-space count for the display path.

## Interface
- `CAPACITY`, 8: number of spaces; count saturates here.
- `GATE_HOLD_CYCLES`, 4: cycles `gate_open` stays high per accepted event (≥1).
- `DEBOUNCE_CYCLES`, 16: stable-sample count when debounce is compiled in (≥2).
- `CW`, derived `$clog2(CAPACITY+1)`: count width; not overridden.
- `clk_40MHz`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `car_enter`  in  1  asynchronous level from entry sensor; rising edge = car at entry.
- `car_exit`  in  1  asynchronous level from exit sensor; rising edge = car at exit.
- `occupancy`  out  CW  cars currently inside.
- `free_spaces`  out  CW  `CAPACITY - occupancy`, registered.
- `full`  out  1  level, high while `occupancy == CAPACITY`.
- `full_trigger`  out  1  one-cycle pulse when `occupancy` becomes `CAPACITY`.
- `gate_open`  out  1  barrier drive.
- `entry_denied`  out  1  one-cycle pulse when an entry is refused because lot is full.

## Operation
- Each sensor passes through a 2-flop synchronizer, then a rising-edge detector producing a registered 1-cycle event pulse.
- Event pulses set sticky flags `pend_in` / `pend_out`; flags clear only when the FSM consumes them. A second edge on a sensor whose flag is already set is merged (lost).
- FSM states: IDLE, OPEN_IN, OPEN_OUT.
- IDLE: if `pend_out` (or exit pulse this cycle): consume; if `occupancy > 0`, decrement, go OPEN_OUT; if `occupancy == 0`, drop event, stay IDLE (underflow ignored, no gate). Else if `pend_in`: consume; if `occupancy < CAPACITY`, increment, go OPEN_IN; else pulse `entry_denied`, stay IDLE.
- Exit has priority over entry when both pending; entry served afterwards.
- OPEN_IN / OPEN_OUT: `gate_open` high, hold counter counts `GATE_HOLD_CYCLES`, then IDLE; new events only latch into flags.
- `full_trigger` asserted on the edge where `occupancy` goes `CAPACITY-1 → CAPACITY`; never re-asserted until occupancy has dropped below `CAPACITY` and refilled.
- `full`, `free_spaces` update on the same edge as `occupancy`.

## Timing
- Reset: `occupancy=0`, `free_spaces=CAPACITY`, `full=0`, `full_trigger=0`, `gate_open=0`, `entry_denied=0`; FSM IDLE, flags and synchronizers clear.
- Reset mid-operation: gate closes immediately, pending events discarded, count returns to 0.
- Sensor sampled high at edge k → event pulse high after edge k+2 → with FSM IDLE, `occupancy`, `gate_open`, `full_trigger`/`entry_denied` change at edge k+3.
- `gate_open` high for exactly `GATE_HOLD_CYCLES` cycles; FSM can accept the next event on the first IDLE cycle after.
- Back-to-back accepted events: gate drops for ≥1 cycle (IDLE) between them.
- Count arithmetic unsigned CW bits; never wraps (saturation guards above).

## Configuration
- `PARKING_DEBOUNCE_EN` defined: after synchronizer, a sensor level must be stable for `DEBOUNCE_CYCLES` consecutive cycles before the filtered level changes; edge detection runs on the filtered level; latency grows by `DEBOUNCE_CYCLES`. Glitches shorter than that produce no event.
- Undefined: no filter, edge detection on synchronized level; `DEBOUNCE_CYCLES` unused.

## Structure
- Shared package `parking_pkg`: FSM state enum (IDLE/OPEN_IN/OPEN_OUT), default `CAPACITY`, `GATE_HOLD_CYCLES`, `DEBOUNCE_CYCLES`.
- Sub-module `sensor_conditioner`: synchronizer, optional debounce, registered rising-edge pulse; instantiated twice.
- Top holds flags, FSM, hold counter, occupancy registers.

## Test plan
- Reset, then 8 entries spaced 20 cycles → occupancy 1..8, `full_trigger` exactly once at 8th, `full=1`, `free_spaces=0`.
- Full lot, one more entry → `entry_denied` 1-cycle pulse, occupancy stays 8, `gate_open` stays 0.
- Empty lot, exit edge → no gate, occupancy 0, no pulses.
- Occupancy 3, enter and exit rise same cycle → exit served first (2), gate 4 cycles, 1 IDLE cycle, entry served (3).
- Occupancy 7→8→7→8 → `full_trigger` pulses twice total.
- With `PARKING_DEBOUNCE_EN`: 5-cycle glitch on `car_enter` → no event; 30-cycle high → one entry.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared definitions for the parking occupancy tracker: gate FSM states and
// default lot parameters used by the top and the sensor conditioners.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OPEN_IN  = 2'd1,
        ST_OPEN_OUT = 2'd2
    } gate_state_e;

    localparam int DEF_CAPACITY         = 8;
    localparam int DEF_GATE_HOLD_CYCLES = 4;
    localparam int DEF_DEBOUNCE_CYCLES  = 16;

endpackage

// File: rtl/parking_occupancy_sensor_conditioner.sv
// Sensor front end: 2-flop synchronizer, optional debounce filter (compiled in
// with PARKING_DEBOUNCE_EN), and a registered one-cycle rising-edge pulse.
module sensor_conditioner
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor,
    output logic event_pulse
);

    logic [1:0] sync_r;
    logic       level_s;
    logic       prev_r;
    logic       pulse_r;

    // Bring the asynchronous sensor level into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], sensor};
        end
    end

`ifdef PARKING_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES);

    logic [DW-1:0] db_cnt_r;
    logic          filt_r;

    // Flip the filtered level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_r <= {DW{1'b0}};
            filt_r   <= 1'b0;
        end else if (sync_r[1] != filt_r) begin
            if (db_cnt_r == DW'(DEBOUNCE_CYCLES - 1)) begin
                filt_r   <= sync_r[1];
                db_cnt_r <= {DW{1'b0}};
            end else begin
                db_cnt_r <= db_cnt_r + DW'(1);
            end
        end else begin
            db_cnt_r <= {DW{1'b0}};
        end
    end

    assign level_s = filt_r;
`else
    // Filter length only matters when the debounce stage is built.
    logic [31:0] unused_debounce;
    assign unused_debounce = 32'(DEBOUNCE_CYCLES);
    assign level_s = sync_r[1];
`endif

    // Registered rising-edge detector on the conditioned level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            prev_r  <= level_s;
            pulse_r <= level_s & ~prev_r;
        end
    end

    assign event_pulse = pulse_r;

endmodule

// File: rtl/parking_occupancy.sv
// Parking lot occupancy tracker: conditions entry/exit sensors, keeps sticky
// pending flags, runs the barrier-gate FSM and maintains registered counts.
// Optional sensor debounce is enabled by defining PARKING_DEBOUNCE_EN.
module parking_occupancy
    import parking_pkg::*;
#(
    parameter int   CAPACITY         = DEF_CAPACITY,
    parameter int   GATE_HOLD_CYCLES = DEF_GATE_HOLD_CYCLES,
    parameter int   DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    localparam int  CW               = $clog2(CAPACITY + 1)
) (
    input  logic          clk_40MHz,
    input  logic          reset,
    input  logic          car_enter,
    input  logic          car_exit,
    output logic [CW-1:0] occupancy,
    output logic [CW-1:0] free_spaces,
    output logic          full,
    output logic          full_trigger,
    output logic          gate_open,
    output logic          entry_denied
);

    localparam int            HW        = $clog2(GATE_HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CAP_V     = CW'(CAPACITY);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(GATE_HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HONE      = HW'(1);

    logic          in_pulse_s, out_pulse_s;
    logic          in_req_s, out_req_s;
    logic          take_in_s, take_out_s;
    logic          deny_s, trig_s;
    logic          pend_in_r, pend_out_r;
    gate_state_e   state_r, state_nxt_s;
    logic [HW-1:0] hold_cnt_r, hold_nxt_s;
    logic [CW-1:0] occ_r, occ_nxt_s;
    logic [CW-1:0] free_r;
    logic          full_r, trig_r, gate_r, deny_r;

    sensor_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry (
        .clk(clk_40MHz), .reset(reset), .sensor(car_enter), .event_pulse(in_pulse_s)
    );

    sensor_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
        .clk(clk_40MHz), .reset(reset), .sensor(car_exit), .event_pulse(out_pulse_s)
    );

    // An event fresh this cycle is serviceable immediately, without waiting for its flag.
    assign in_req_s  = pend_in_r  | in_pulse_s;
    assign out_req_s = pend_out_r | out_pulse_s;

    // Gate FSM: exit wins over entry; counts saturate at 0 and CAPACITY.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_cnt_r;
        occ_nxt_s   = occ_r;
        take_in_s   = 1'b0;
        take_out_s  = 1'b0;
        deny_s      = 1'b0;
        trig_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                hold_nxt_s = {HW{1'b0}};
                if (out_req_s) begin
                    take_out_s = 1'b1;
                    if (occ_r != {CW{1'b0}}) begin
                        occ_nxt_s   = occ_r - ONE;
                        state_nxt_s = ST_OPEN_OUT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (in_req_s) begin
                    take_in_s = 1'b1;
                    if (occ_r < CAP_V) begin
                        occ_nxt_s   = occ_r + ONE;
                        state_nxt_s = ST_OPEN_IN;
                        trig_s      = (occ_r == (CAP_V - ONE));
                    end else begin
                        deny_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OPEN_IN, ST_OPEN_OUT: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_nxt_s = ST_IDLE;
                    hold_nxt_s  = {HW{1'b0}};
                end else begin
                    hold_nxt_s = hold_cnt_r + HONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                hold_nxt_s  = {HW{1'b0}};
            end
        endcase
    end

    // State, pending flags, counts and all outputs registered together.
    always_ff @(posedge clk_40MHz or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= {HW{1'b0}};
            pend_in_r  <= 1'b0;
            pend_out_r <= 1'b0;
            occ_r      <= {CW{1'b0}};
            free_r     <= CAP_V;
            full_r     <= 1'b0;
            trig_r     <= 1'b0;
            gate_r     <= 1'b0;
            deny_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            pend_in_r  <= in_req_s  & ~take_in_s;
            pend_out_r <= out_req_s & ~take_out_s;
            occ_r      <= occ_nxt_s;
            free_r     <= CAP_V - occ_nxt_s;
            full_r     <= (occ_nxt_s == CAP_V);
            trig_r     <= trig_s;
            gate_r     <= (state_nxt_s != ST_IDLE);
            deny_r     <= deny_s;
        end
    end

    assign occupancy    = occ_r;
    assign free_spaces  = free_r;
    assign full         = full_r;
    assign full_trigger = trig_r;
    assign gate_open    = gate_r;
    assign entry_denied = deny_r;

endmodule
